// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round/schedule functions and the core FSM state type.
package sha256_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } state_e;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Rotate within a 32-bit operand; the operand never widens before shifting.
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round. Working state is packed {a,b,c,d,e,f,g,h}, a in the top word.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] st_i,
   input  logic [31:0]  k_i,
   input  logic [31:0]  w_i,
   output logic [255:0] st_o
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   assign {a, b, c, d, e, f, g, h} = st_i;
   assign t1   = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
   assign t2   = bsig0(a) + maj(a, b, c);
   assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative multi-block SHA-256 compression: R rounds per clock, H chained across blocks.
// Handshake: a block transfers on a rising edge where blk_valid and blk_ready are both high;
// blk_ready is high only in IDLE, blk_valid while busy is ignored, and M/flags are captured
// at the transfer edge so the source may change them afterwards.
module sha256_iter_core
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic         blk_first,
   input  logic         blk_last,
   input  logic [0:511] M,
   output logic [0:255] hash,
   output logic         hash_valid,
   output logic         busy
);

   localparam int         R      = ROUNDS_PER_CYCLE;
   localparam logic [5:0] T_LAST = 6'(64 - R);

   state_e        state_q;
   logic [5:0]    t_q;
   logic          first_q;
   logic          last_q;
   logic [31:0]   w_q [0:15];
   logic [31:0]   w_d [0:15];
   logic [31:0]   h_q [0:7];
   logic [255:0]  st_q;
   logic [255:0]  hash_q;
   logic          hash_valid_q;
   logic [255:0]  chain [0:R];
   logic [255:0]  h_flat;
   logic [255:0]  iv_flat;
   logic [255:0]  h_new;

   // R rounds chained combinationally; round j of this cycle uses K[t+j] and W[t+j] = w_q[j].
   assign chain[0] = st_q;
   for (genvar j = 0; j < R; j++) begin : g_rounds
      logic [5:0] k_idx;
      assign k_idx = t_q + 6'(j);
      sha256_round u_round (
         .st_i (chain[j]),
         .k_i  (K[k_idx]),
         .w_i  (w_q[j]),
         .st_o (chain[j+1])
      );
   end

   // Message schedule: extend the 16-word window by R words, then slide it forward by R.
   always_comb begin
      logic [31:0] ext [0:15+R];
      for (int k = 0; k < 16; k++) ext[k] = w_q[k];
      for (int j = 0; j < R; j++)
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
      for (int k = 0; k < 16; k++) w_d[k] = ext[k+R];
   end

   // Flattened chaining values and the feed-forward sum; a first block adds onto IV, not H.
   always_comb begin
      h_flat  = '0;
      iv_flat = '0;
      h_new   = '0;
      for (int i = 0; i < 8; i++) begin
         h_flat[255-32*i -: 32]  = h_q[i];
         iv_flat[255-32*i -: 32] = IV[i];
         h_new[255-32*i -: 32]   = (first_q ? IV[i] : h_q[i]) + st_q[255-32*i -: 32];
      end
   end

   // Control FSM with the working state, schedule window, H registers and digest output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         t_q          <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         st_q         <= '0;
         hash_q       <= '0;
         hash_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++)  h_q[i] <= IV[i];
         for (int k = 0; k < 16; k++) w_q[k] <= '0;
      end else begin
         hash_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (blk_valid) begin
                  first_q <= blk_first;
                  last_q  <= blk_last;
                  for (int k = 0; k < 16; k++) w_q[k] <= M[k*32 +: 32];
                  st_q    <= blk_first ? iv_flat : h_flat;
                  t_q     <= '0;
                  state_q <= S_ROUND;
               end
            end
            S_ROUND: begin
               st_q <= chain[R];
               w_q  <= w_d;
               t_q  <= t_q + 6'(R);
               if (t_q == T_LAST) state_q <= S_FINAL;
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) h_q[i] <= h_new[255-32*i -: 32];
               if (last_q) begin
                  hash_q       <= h_new;
                  hash_valid_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign blk_ready  = (state_q == S_IDLE);
   assign busy       = ~blk_ready;
   assign hash       = hash_q;
   assign hash_valid = hash_valid_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: known-answer vectors at R=1/4/8, latency, reset abort,
// held-valid back-to-back acceptance with scrambled inputs during the rounds.
module tb_sha256_iter_core;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT wiring ----------------
   logic         blk_first, blk_last;
   logic [511:0] m;
   logic         v1, v4, v8;
   logic         rdy1, rdy4, rdy8;
   logic [255:0] hs1, hs4, hs8;
   logic         hv1, hv4, hv8;
   logic         bz1, bz4, bz8;

   sha256_iter_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
      .clk(clk), .reset(reset), .blk_valid(v1), .blk_ready(rdy1), .blk_first(blk_first),
      .blk_last(blk_last), .M(m), .hash(hs1), .hash_valid(hv1), .busy(bz1));
   sha256_iter_core #(.ROUNDS_PER_CYCLE(4)) u_r4 (
      .clk(clk), .reset(reset), .blk_valid(v4), .blk_ready(rdy4), .blk_first(blk_first),
      .blk_last(blk_last), .M(m), .hash(hs4), .hash_valid(hv4), .busy(bz4));
   sha256_iter_core #(.ROUNDS_PER_CYCLE(8)) u_r8 (
      .clk(clk), .reset(reset), .blk_valid(v8), .blk_ready(rdy8), .blk_first(blk_first),
      .blk_last(blk_last), .M(m), .hash(hs8), .hash_valid(hv8), .busy(bz8));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [255:0] exp1_q[$];
   logic [255:0] exp4_q[$];
   logic [255:0] exp8_q[$];
   int hv_cyc1 = 0, hv_cyc4 = 0, hv_cyc8 = 0;

   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_448_0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_448_1 = {{15{32'h0}}, 32'h000001c0};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};

   // Digest monitors: each pulse must match the oldest expected digest.
   always @(negedge clk) begin
      logic [255:0] e;
      if (!reset) begin
         checks++;
         if (bz1 !== ~rdy1) begin
            errors++;
            $display("FAIL busy_vs_ready busy=%b ready=%b required busy=~ready", bz1, rdy1);
         end
      end
      if (hv1 === 1'b1) begin
         hv_cyc1 = cyc;
         checks++;
         if (exp1_q.size() == 0) begin
            errors++;
            $display("FAIL r1_unexpected_pulse hash=%h required no pulse", hs1);
         end else begin
            e = exp1_q.pop_front();
            if (hs1 !== e) begin
               errors++;
               $display("FAIL r1_digest got=%h required=%h", hs1, e);
            end
         end
      end
      if (hv4 === 1'b1) begin
         hv_cyc4 = cyc;
         checks++;
         if (exp4_q.size() == 0) begin
            errors++;
            $display("FAIL r4_unexpected_pulse hash=%h required no pulse", hs4);
         end else begin
            e = exp4_q.pop_front();
            if (hs4 !== e) begin
               errors++;
               $display("FAIL r4_digest got=%h required=%h", hs4, e);
            end
         end
      end
      if (hv8 === 1'b1) begin
         hv_cyc8 = cyc;
         checks++;
         if (exp8_q.size() == 0) begin
            errors++;
            $display("FAIL r8_unexpected_pulse hash=%h required no pulse", hs8);
         end else begin
            e = exp8_q.pop_front();
            if (hs8 !== e) begin
               errors++;
               $display("FAIL r8_digest got=%h required=%h", hs8, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic ready_of(input int inst);
      if (inst == 1) return rdy1;
      else if (inst == 4) return rdy4;
      else return rdy8;
   endfunction

   function automatic int qsize(input int inst);
      if (inst == 1) return exp1_q.size();
      else if (inst == 4) return exp4_q.size();
      else return exp8_q.size();
   endfunction

   task automatic set_valid(input int inst, input logic v);
      if (inst == 1) v1 = v;
      else if (inst == 4) v4 = v;
      else v8 = v;
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic check_vec(input string name, input logic [255:0] got, input logic [255:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   // Present one block and return the cycle count just after the accepting edge.
   task automatic send(input int inst, input logic [511:0] blk, input logic f, input logic l,
                       output int acc);
      int n;
      @(negedge clk);
      m = blk;
      blk_first = f;
      blk_last = l;
      set_valid(inst, 1'b1);
      n = 0;
      while (!ready_of(inst) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL send_timeout inst=%0d ready=0 required 1 within 200 cycles", inst);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      set_valid(inst, 1'b0);
   endtask

   task automatic wait_done(input int inst);
      int n;
      n = 0;
      while (qsize(inst) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (qsize(inst) != 0) begin
         errors++;
         $display("FAIL drain_timeout inst=%0d pending=%0d required 0", inst, qsize(inst));
      end
      @(negedge clk);
   endtask

   task automatic wait_ready1();
      int n;
      n = 0;
      while (!rdy1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!rdy1) begin
         errors++;
         $display("FAIL idle_timeout ready=%b required 1", rdy1);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [511:0] b0;
      logic [511:0] b1;
      int           nblk;
      logic [255:0] dig;
   } vec_t;

   vec_t vecs [3];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int acc, acc_a, acc_b, acc4, acc8, n;
      logic [255:0] prev_dig;

      vecs[0] = '{b0: BLK_ABC,   b1: '0,        nblk: 1, dig: DIG_ABC};
      vecs[1] = '{b0: BLK_448_0, b1: BLK_448_1, nblk: 2, dig: DIG_448};
      vecs[2] = '{b0: BLK_EMPTY, b1: '0,        nblk: 1, dig: DIG_EMPTY};

      reset = 1'b1;
      v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
      blk_first = 1'b0; blk_last = 1'b0; m = '0;
      repeat (3) @(negedge clk);

      // Reset state of all three instances.
      check_int("rst_ready_r1", int'(rdy1), 1);
      check_int("rst_busy_r1", int'(bz1), 0);
      check_int("rst_hv_r1", int'(hv1), 0);
      check_vec("rst_hash_r1", hs1, '0);
      check_int("rst_ready_r4", int'(rdy4), 1);
      check_int("rst_ready_r8", int'(rdy8), 1);
      check_vec("rst_hash_r8", hs8, '0);
      reset = 1'b0;

      // Known-answer vectors at one round per clock.
      prev_dig = '0;
      for (int v = 0; v < 3; v++) begin
         if (vecs[v].nblk == 2) begin
            send(1, vecs[v].b0, 1'b1, 1'b0, acc);
            wait_ready1();
            repeat (3) @(negedge clk);
            check_vec("nonlast_hash_hold", hs1, prev_dig);
            exp1_q.push_back(vecs[v].dig);
            send(1, vecs[v].b1, 1'b0, 1'b1, acc);
         end else begin
            exp1_q.push_back(vecs[v].dig);
            send(1, vecs[v].b0, 1'b1, 1'b1, acc);
         end
         wait_done(1);
         check_int("latency_r1", hv_cyc1 - acc, 65);
         check_vec("hash_hold_after", hs1, vecs[v].dig);
         prev_dig = vecs[v].dig;
      end

      // Four and eight rounds per clock.
      exp4_q.push_back(DIG_ABC);
      exp8_q.push_back(DIG_ABC);
      send(4, BLK_ABC, 1'b1, 1'b1, acc4);
      send(8, BLK_ABC, 1'b1, 1'b1, acc8);
      wait_done(4);
      wait_done(8);
      check_int("latency_r4", hv_cyc4 - acc4, 17);
      check_int("latency_r8", hv_cyc8 - acc8, 9);

      // Reset 20 clocks into a block, then resend without blk_first.
      send(1, BLK_ABC, 1'b1, 1'b1, acc);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_int("abort_ready", int'(rdy1), 1);
      check_int("abort_hv", int'(hv1), 0);
      check_vec("abort_hash", hs1, '0);
      exp1_q.push_back(DIG_ABC);
      send(1, BLK_ABC, 1'b0, 1'b1, acc);
      wait_done(1);
      check_int("latency_after_abort", hv_cyc1 - acc, 65);

      // Held blk_valid with inputs scrambled while busy; second block taken on first IDLE cycle.
      exp1_q.push_back(DIG_448);
      @(negedge clk);
      m = BLK_448_0;
      blk_first = 1'b1;
      blk_last = 1'b0;
      v1 = 1'b1;
      @(posedge clk);
      #1;
      acc_a = cyc;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!rdy1) begin
            for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom;
            blk_first = 1'($urandom_range(0, 1));
            blk_last = 1'($urandom_range(0, 1));
         end
      end while (!rdy1 && n < 200);
      m = BLK_448_1;
      blk_first = 1'b0;
      blk_last = 1'b1;
      @(posedge clk);
      #1;
      acc_b = cyc;
      v1 = 1'b0;
      check_int("held_valid_period", acc_b - acc_a, 66);
      wait_done(1);
      check_vec("held_valid_hash", hs1, DIG_448);

      repeat (5) @(negedge clk);
      check_int("no_stray_pulses", exp1_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
